// File: rtl/mio_responder_pkg.sv
`default_nettype none
// ============================================================
// mio_responder_pkg : shared decode constants and FSM states
// Rev 1.0
// ============================================================
package mio_responder_pkg;

  localparam logic [31:0] IO_BASE = 32'hF000_0000;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_TIMER  = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mio_byte_ram.sv
`default_nettype none
// ============================================================
// mio_byte_ram : single-port word RAM, byte-strobe writes,
// registered read port. Contents are never reset.
// Rev 1.0
// ============================================================
module mio_byte_ram
  import mio_responder_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [3:0]                 be,
  input  logic [$clog2(WORDS)-1:0]   addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mio_responder.sv
`default_nettype none
// ============================================================
// mio_responder : CPU memory/IO responder with wait states,
// byte-strobe data RAM and LED/timer/compare/status MMIO.
// Rev 1.0
// ============================================================
module mio_responder #(
  parameter int                    ADDR_SIZE   = 32,
  parameter int                    XLEN        = 32,
  parameter int                    RAM_WORDS   = 1024,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [ADDR_SIZE-1:0]  IO_BASE     = mio_responder_pkg::IO_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  mem_w,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [3:0]            swlength,
  output logic [XLEN-1:0]       rdata,
  output logic                  ready,
  output logic [15:0]           led_out,
  output logic                  timer_irq
);

  import mio_responder_pkg::*;

  localparam int         AW        = $clog2(RAM_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              is_io_q, is_io_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [15:0]       led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              pending_q, pending_d;

  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic              io_we;
  logic [XLEN-1:0]   io_rdata;

  // The RAM read is registered, so present the incoming address while idle;
  // the word is then ready by the RESP cycle even with zero wait states.
  assign ram_addr = (state_q == ST_IDLE) ? addr[AW+1:2] : idx_q;
  assign ram_we   = (state_q == ST_RESP) && we_q && !is_io_q;
  assign io_we    = (state_q == ST_RESP) && we_q && is_io_q;

  mio_byte_ram #(
    .WORDS (RAM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be_q),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    io_rdata = '0;
    case (off_q)
      OFF_LED:   io_rdata = {16'h0000, led_q};
      OFF_TIMER: io_rdata = timer_q;
      OFF_CMP:   io_rdata = cmp_q;
      default:   io_rdata = {31'd0, pending_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    is_io_d = is_io_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = mem_w;
          is_io_d = (addr >= IO_BASE);
          idx_d   = addr[AW+1:2];
          off_d   = addr[3:2];
          wdata_d = wdata;
          be_d    = swlength;
          cnt_d   = WAIT_LOAD;
          if (WAIT_CYCLES == 0) state_d = ST_RESP;
          else                  state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        if (!we_q) rdata_d = is_io_q ? io_rdata : ram_rdata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d   = timer_q + 32'd1;
    led_d     = led_q;
    cmp_d     = cmp_q;
    pending_d = pending_q;
    if (io_we) begin
      case (off_q)
        OFF_LED: begin
          if (be_q[0]) led_d[7:0]  = wdata_q[7:0];
          if (be_q[1]) led_d[15:8] = wdata_q[15:8];
        end
        OFF_CMP:    cmp_d = merge_bytes(cmp_q, wdata_q, be_q);
        OFF_STATUS: if (be_q[0] && wdata_q[0]) pending_d = 1'b0;
        default: ;
      endcase
    end
    // Placed after the clear so a simultaneous match keeps the flag set.
    if ((cmp_q != 32'd0) && (timer_q == cmp_q)) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      is_io_q   <= 1'b0;
      idx_q     <= '0;
      off_q     <= 2'd0;
      wdata_q   <= '0;
      be_q      <= 4'd0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      led_q     <= 16'd0;
      timer_q   <= 32'd0;
      cmp_q     <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      is_io_q   <= is_io_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      pending_q <= pending_d;
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign led_out   = led_q;
  assign timer_irq = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_mio_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// tb_mio_responder : scoreboard bench for mio_responder
// Rev 1.0
// ============================================================
module tb_mio_responder;

  localparam logic [31:0] IO = 32'hF000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // main instance, WAIT_CYCLES = 1
  logic        req, mem_w;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  swlength;
  logic        ready, timer_irq;
  logic [15:0] led_out;
  // WAIT_CYCLES = 0 instance
  logic        req0, mem_w0, ready0, irq0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  swl0;
  logic [15:0] led0;
  // WAIT_CYCLES = 3 instance
  logic        req3, mem_w3, ready3, irq3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  swl3;
  logic [15:0] led3;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] t_model;

  mio_responder #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req(req), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .swlength(swlength), .rdata(rdata), .ready(ready),
    .led_out(led_out), .timer_irq(timer_irq));

  mio_responder #(.WAIT_CYCLES(0), .RAM_WORDS(64)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .mem_w(mem_w0), .addr(addr0),
    .wdata(wdata0), .swlength(swl0), .rdata(rdata0), .ready(ready0),
    .led_out(led0), .timer_irq(irq0));

  mio_responder #(.WAIT_CYCLES(3), .RAM_WORDS(64)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .mem_w(mem_w3), .addr(addr3),
    .wdata(wdata3), .swlength(swl3), .rdata(rdata3), .ready(ready3),
    .led_out(led3), .timer_irq(irq3));

  // Reference free-running timer
  always @(posedge clk or negedge reset) begin
    if (!reset) t_model <= 32'd0;
    else        t_model <= t_model + 32'd1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one transaction on the main instance; returns the data seen with
  // ready and the number of edges from the req-sampling edge (-1 = none).
  task automatic xfer(input bit sync, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] got, output int lat);
    if (sync) begin
      @(posedge clk); #1;
    end
    req = 1'b1; mem_w = we; addr = a; wdata = d; swlength = s;
    @(posedge clk); #1;
    req = 1'b0;
    got = 32'h0; lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got = rdata; lat = c;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want 0", led_out); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_read_latency();
    logic [31:0] got, e;
    int lat;
    xfer(1, 1'b1, 32'h10, 32'h0, 4'hF, got, lat);
    xfer(1, 1'b1, 32'h40, 32'h0, 4'hF, got, lat);
    exp_q.push_back(32'h0);
    xfer(1, 1'b0, 32'h10, 32'hFFFF_FFFF, 4'h0, got, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d want 2", lat); end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL read_zero: got %h want %h", got, e); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_width: got %b want 0", ready); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] got, e;
    int lat;
    xfer(1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b1111, got, lat);
    xfer(1, 1'b1, 32'h20, 32'h0000_0011, 4'b0001, got, lat);
    exp_q.push_back(32'hAABB_CC11);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL strobe_lane0: got %h want %h", got, e); end
    xfer(1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, got, lat);
    exp_q.push_back(32'hAABB_CC11);
    xfer(1, 1'b0, 32'h1020, 32'h0, 4'h0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL strobe_none_alias: got %h want %h", got, e); end
    xfer(1, 1'b1, 32'h1020, 32'h5500_0000, 4'b1000, got, lat);
    exp_q.push_back(32'h55BB_CC11);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL strobe_lane3: got %h want %h", got, e); end
  endtask

  task automatic test_mmio_led();
    logic [31:0] got, e;
    int lat;
    xfer(1, 1'b1, IO, 32'h1234_5678, 4'b1111, got, lat);
    checks++; if (led_out !== 16'h5678) begin errors++; $display("FAIL led_write: got %h want 5678", led_out); end
    xfer(1, 1'b1, IO + 32'h10, 32'hFFFF_0000, 4'b1100, got, lat);
    checks++; if (led_out !== 16'h5678) begin errors++; $display("FAIL led_upper_lanes: got %h want 5678", led_out); end
    exp_q.push_back(32'h0000_5678);
    xfer(1, 1'b0, IO + 32'h20, 32'h0, 4'h0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL led_read: got %h want %h", got, e); end
  endtask

  task automatic test_timer_read();
    logic [31:0] got, e;
    int lat;
    xfer(1, 1'b1, IO + 32'h4, 32'h0, 4'hF, got, lat);
    xfer(1, 1'b0, IO + 32'h4, 32'h0, 4'h0, got, lat);
    e = t_model - 32'd1;
    checks++; if (got !== e) begin errors++; $display("FAIL timer_read: got %h want %h", got, e); end
  endtask

  task automatic test_irq();
    logic [31:0] got;
    int lat;
    bit seen;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(1, 1'b1, IO + 32'h8, 32'd50, 4'hF, got, lat);
    xfer(1, 1'b1, IO + 32'hC, 32'h1, 4'b0001, got, lat);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (t_model == 32'd50) begin
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", timer_irq); end
      end
      if (t_model == 32'd51) begin
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", timer_irq); end
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin checks++; errors++; $display("FAIL irq_timeout: got no match want timer 51"); end
    xfer(1, 1'b1, IO + 32'hC, 32'h1, 4'b0001, got, lat);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", timer_irq); end
  endtask

  task automatic test_clear_vs_set();
    logic [31:0] got, c;
    int lat;
    bit found;
    c = t_model + 32'd30;
    xfer(1, 1'b1, IO + 32'h8, c, 4'hF, got, lat);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_before_match: got %b want 0", timer_irq); end
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (t_model == c - 32'd2) begin found = 1'b1; break; end
    end
    if (!found) begin checks++; errors++; $display("FAIL align_timeout: got no slot want timer %h", c - 32'd2); end
    // RESP of this clear lands in the cycle where timer == compare
    xfer(0, 1'b1, IO + 32'hC, 32'h1, 4'b0001, got, lat);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", timer_irq); end
  endtask

  task automatic test_back_to_back();
    logic want;
    @(posedge clk); #1;
    req0 = 1'b1; mem_w0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; swl0 = 4'h0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      want = (c % 2 == 1);
      checks++; if (ready0 !== want) begin errors++; $display("FAIL b2b_cycle%0d: got %b want %b", c, ready0, want); end
    end
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  task automatic test_req_drop();
    int pulses, first;
    logic [31:0] got, e;
    @(posedge clk); #1;
    req3 = 1'b1; mem_w3 = 1'b1; addr3 = 32'h8; wdata3 = 32'h77; swl3 = 4'hF;
    @(posedge clk); #1;
    req3 = 1'b0; addr3 = 32'hC; wdata3 = 32'hDEAD_BEEF;
    pulses = 0; first = -1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ready3 === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      @(posedge clk);
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
    checks++; if (first !== 4) begin errors++; $display("FAIL drop_latency: got %0d want 4", first); end
    #1;
    exp_q.push_back(32'h77);
    req3 = 1'b1; mem_w3 = 1'b0; addr3 = 32'h8; swl3 = 4'h0;
    @(posedge clk); #1;
    req3 = 1'b0;
    got = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready3 === 1'b1) begin got = rdata3; break; end
      @(posedge clk);
    end
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL drop_write_landed: got %h want %h", got, e); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got, e;
    int lat, pulses;
    xfer(1, 1'b1, 32'h40, 32'h1, 4'hF, got, lat);
    @(posedge clk); #1;
    req = 1'b1; mem_w = 1'b1; addr = 32'h40; wdata = 32'hDEAD_BEEF; swlength = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_ready: got %0d pulses want 0", pulses); end
    exp_q.push_back(32'h1);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL abort_no_write: got %h want %h", got, e); end
  endtask

  initial begin
    reset = 1'b0;
    req = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0; swlength = '0;
    req0 = 1'b0; mem_w0 = 1'b0; addr0 = '0; wdata0 = '0; swl0 = '0;
    req3 = 1'b0; mem_w3 = 1'b0; addr3 = '0; wdata3 = '0; swl3 = '0;
    test_reset();
    test_read_latency();
    test_byte_strobe();
    test_mmio_led();
    test_timer_read();
    test_irq();
    test_clear_vs_set();
    test_back_to_back();
    test_req_drop();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
